invite_scheduler: RTL and testbench

INVITE_SCHEDULER -- requirements
Module: invite_scheduler

---
 rtl/invite_pkg.sv | 14 +
 rtl/invite_check.sv | 30 +++
 rtl/invite_scheduler.sv | 111 +++++++++++
 tb/tb_invite_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/invite_pkg.sv
// Shared types and constants for the invitation scheduler.
package invite_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int              SEL_W     = 4;
   localparam logic [SEL_W-1:0] LAST_CAND = 4'd15;

endpackage

// File: rtl/invite_check.sv
// Combinational guest-selection rule checker.
// sel = {d,c,b,a}: bit0 Ana, bit1 Bea, bit2 Carmen, bit3 Diana.
module invite_check
   import invite_pkg::*;
#(
   parameter int MAX_GUESTS = 3
) (
   input  logic [SEL_W-1:0] sel,
   output logic             ok
);

   logic       a, b, c, d;
   logic [2:0] pop;

   assign a = sel[0];
   assign b = sel[1];
   assign c = sel[2];
   assign d = sel[3];

   // Head count of the candidate party.
   assign pop = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};

   // Size limits plus the three pairwise constraints, written as implications.
   assign ok = (pop != 3'd0)
            && (pop <= 3'(MAX_GUESTS))
            && (!b || c)
            && (!(a && c) || b || d)
            && (!(c || d || !a) || b);

endmodule

// File: rtl/invite_scheduler.sv
// Invitation scheduler: scans all 16 guest subsets in ascending order and
// emits every subset that satisfies the rules through a valid/ready port.
// Optional macro INVITE_COUNT_EN adds the n_valid emission counter output.
module invite_scheduler
   import invite_pkg::*;
#(
   parameter int MAX_GUESTS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [SEL_W-1:0] out_sel,
   output logic             busy,
   output logic             done
`ifdef INVITE_COUNT_EN
   ,
   output logic [2:0]       n_valid
`endif
);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] cand, cand_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic             valid_nxt;
   logic             cand_ok;

   invite_check #(
      .MAX_GUESTS(MAX_GUESTS)
   ) u_check (
      .sel(cand),
      .ok (cand_ok)
   );

   // State, candidate and output registers; reset abandons any scan in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cand      <= '0;
         out_valid <= 1'b0;
         out_sel   <= '0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         out_valid <= valid_nxt;
         out_sel   <= sel_nxt;
      end
   end

   // Next-state logic: one candidate per SCAN edge, hold in EMIT until accepted.
   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      valid_nxt = out_valid;
      sel_nxt   = out_sel;
      case (state)
         IDLE: begin
            if (start) begin
               cand_nxt  = '0;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (cand_ok) begin
               sel_nxt   = cand;
               valid_nxt = 1'b1;
               state_nxt = EMIT;
            end else if (cand == LAST_CAND) begin
               state_nxt = DONE;
            end else begin
               cand_nxt = cand + 4'd1;
            end
         end
         EMIT: begin
            if (out_valid && out_ready) begin
               valid_nxt = 1'b0;
               if (cand == LAST_CAND) begin
                  state_nxt = DONE;
               end else begin
                  cand_nxt  = cand + 4'd1;
                  state_nxt = SCAN;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state == SCAN) || (state == EMIT);
   assign done = (state == DONE);

`ifdef INVITE_COUNT_EN
   // Emission counter: cleared by an accepted start, bumped per handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_valid <= 3'd0;
      end else if (state == IDLE && start) begin
         n_valid <= 3'd0;
      end else if (state == EMIT && out_valid && out_ready) begin
         n_valid <= n_valid + 3'd1;
      end
   end
`endif

endmodule

// File: tb/tb_invite_scheduler.sv
// Bench for invite_scheduler: fixed-timing table, corner sequences and
// randomized handshakes checked against a rule-level reference model.
module tb_invite_scheduler;

   logic       clk = 1'b0;
   logic       rst_n, start, start2, out_ready;
   logic       out_valid, busy, done;
   logic [3:0] out_sel;
   logic       v2, b2, d2;
   logic [3:0] s2;
`ifdef INVITE_COUNT_EN
   logic [2:0] n_valid, n2;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   invite_scheduler #(.MAX_GUESTS(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready),
      .out_valid(out_valid), .out_sel(out_sel), .busy(busy), .done(done)
`ifdef INVITE_COUNT_EN
      , .n_valid(n_valid)
`endif
   );

   invite_scheduler #(.MAX_GUESTS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .out_ready(out_ready),
      .out_valid(v2), .out_sel(s2), .busy(b2), .done(d2)
`ifdef INVITE_COUNT_EN
      , .n_valid(n2)
`endif
   );

   typedef struct {
      int         cyc;
      bit         start;
      bit         valid;
      logic [3:0] sel;
      bit         busy;
      bit         done;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference rules, straight from the selection definition.
   function automatic bit ref_ok(input logic [3:0] v, input int maxg);
      bit a, b, c, d;
      int pc;
      a  = v[0]; b = v[1]; c = v[2]; d = v[3];
      pc = $countones(v);
      return (pc >= 1) && (pc <= maxg) && (!b || c)
          && (!(a && c) || (b || d)) && (!(c || d || !a) || b);
   endfunction

   task automatic do_reset();
      start = 0; start2 = 0; out_ready = 0;
      rst_n = 0;
      step(); step();
      rst_n = 1;
      step();
   endtask

   // One full scan with random ready and spurious start pulses.
   task automatic run_scan(input string tag);
      logic [3:0] exp_q[$];
      int         acc = 0, emit = 0, k = 0, done_k = -1, busy_bad = 0;
      bit         pv, pr;
      logic [3:0] ps;
      for (int s = 0; s < 16; s++) begin
         logic [3:0] sv;
         sv = s[3:0];
         if (ref_ok(sv, 3)) exp_q.push_back(sv);
      end
      out_ready = 1'($urandom_range(0, 1));
      start = 1; step(); start = 0;
      while (done_k < 0 && k < 300) begin
         out_ready = 1'($urandom_range(0, 1));
         start     = ($urandom_range(0, 3) == 0);
         pv = out_valid; pr = out_ready; ps = out_sel;
         step(); k++;
         if (pv) emit++;
         if (pv && pr) begin
            if (acc < exp_q.size()) chk({tag, "_sel"}, ps, exp_q[acc]);
            acc++;
         end else if (pv) begin
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_sel"}, out_sel, ps);
         end
         if (done) done_k = k;
         else if (!busy) busy_bad++;
      end
      start = 0;
      chk({tag, "_done_edge"}, done_k, 16 + emit);
      chk({tag, "_accepted"}, acc, exp_q.size());
      chk({tag, "_busy_gap"}, busy_bad, 0);
`ifdef INVITE_COUNT_EN
      chk({tag, "_n_valid"}, n_valid, exp_q.size());
`endif
      start = 1; step(); start = 0;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle_busy"}, busy, 0);
      step();
      chk({tag, "_idle_after"}, {busy, out_valid}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl[$];
      logic [3:0] exp2[$];
      logic [3:0] got2[$];
      int         t, bad, done2_k;

      // Ready-high trace, with start re-pulsed in SCAN (cyc 5) and DONE (cyc 21).
      tbl.push_back('{1,  0, 0, 4'h0, 1, 0});
      tbl.push_back('{2,  0, 1, 4'h1, 1, 0});
      tbl.push_back('{3,  0, 0, 4'h0, 1, 0});
      tbl.push_back('{5,  1, 0, 4'h0, 1, 0});
      tbl.push_back('{8,  0, 1, 4'h6, 1, 0});
      tbl.push_back('{9,  0, 0, 4'h0, 1, 0});
      tbl.push_back('{10, 0, 1, 4'h7, 1, 0});
      tbl.push_back('{11, 0, 0, 4'h0, 1, 0});
      tbl.push_back('{18, 0, 1, 4'hE, 1, 0});
      tbl.push_back('{19, 0, 0, 4'h0, 1, 0});
      tbl.push_back('{20, 0, 0, 4'h0, 0, 1});
      tbl.push_back('{21, 1, 0, 4'h0, 0, 0});
      tbl.push_back('{22, 0, 0, 4'h0, 0, 0});

      do_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_sel", out_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef INVITE_COUNT_EN
      chk("rst_n_valid", n_valid, 0);
`endif

      out_ready = 1; start = 1; step(); start = 0;
      for (int k = 1; k <= 22; k++) begin
         start = 0;
         foreach (tbl[i]) if (tbl[i].cyc == k && tbl[i].start) start = 1;
         step();
         start = 0;
         foreach (tbl[i]) begin
            if (tbl[i].cyc == k) begin
               chk($sformatf("tbl%0d_valid", k), out_valid, tbl[i].valid);
               chk($sformatf("tbl%0d_busy", k), busy, tbl[i].busy);
               chk($sformatf("tbl%0d_done", k), done, tbl[i].done);
               if (tbl[i].valid) chk($sformatf("tbl%0d_sel", k), out_sel, tbl[i].sel);
            end
         end
      end
`ifdef INVITE_COUNT_EN
      chk("tbl_n_valid", n_valid, 4);
`endif

      // Back-pressure on 0110 for five cycles.
      do_reset();
      out_ready = 1; start = 1; step(); start = 0;
      t = 0;
      while (!(out_valid && out_sel == 4'b0110) && t < 40) begin step(); t++; end
      out_ready = 0;
      chk("stall_reach", {out_valid, out_sel}, 5'b1_0110);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall%0d", i), {out_valid, out_sel}, 5'b1_0110);
      end
      out_ready = 1;
      step();
      t = 0;
      while (!out_valid && t < 10) begin step(); t++; end
      chk("stall_next", {out_valid, out_sel}, 5'b1_0111);
      t = 0;
      while (!done && t < 40) begin step(); t++; end

      // Reset while 0111 is waiting in EMIT.
      do_reset();
      out_ready = 1; start = 1; step(); start = 0;
      t = 0;
      while (!(out_valid && out_sel == 4'b0111) && t < 40) begin step(); t++; end
      out_ready = 0;
      chk("mid_reach", {out_valid, out_sel}, 5'b1_0111);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_outs", {out_valid, out_sel, busy, done}, 0);
`ifdef INVITE_COUNT_EN
      chk("mid_rst_n_valid", n_valid, 0);
`endif
      step(); step();
      rst_n = 1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (out_valid || busy || done) bad++;
      end
      chk("post_rst_quiet", bad, 0);
      start = 1; step(); start = 0;
      step();
      chk("restart_e1", out_valid, 0);
      step();
      chk("restart_e2", {out_valid, out_sel}, 5'b1_0001);
      out_ready = 1;
      t = 0;
      while (!done && t < 40) begin step(); t++; end
      chk("restart_done", done, 1);
      step();

      // MAX_GUESTS=2 instance.
      do_reset();
      for (int s = 0; s < 16; s++) begin
         logic [3:0] sv;
         sv = s[3:0];
         if (ref_ok(sv, 2)) exp2.push_back(sv);
      end
      out_ready = 1; start2 = 1; step(); start2 = 0;
      done2_k = -1;
      for (int k = 1; k <= 30; k++) begin
         bit         pv;
         logic [3:0] ps;
         pv = v2; ps = s2;
         step();
         if (pv) got2.push_back(ps);
         if (d2 && done2_k < 0) done2_k = k;
      end
      chk("max2_count", got2.size(), exp2.size());
      foreach (exp2[i]) if (i < got2.size()) chk($sformatf("max2_sel%0d", i), got2[i], exp2[i]);
      chk("max2_done_edge", done2_k, 16 + exp2.size());
`ifdef INVITE_COUNT_EN
      chk("max2_n_valid", n2, 2);
`endif

      // Randomized handshakes.
      do_reset();
      for (int r = 0; r < 4; r++) run_scan($sformatf("rnd%0d", r));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
